conv_mac_acc: RTL and testbench

- Streaming signed multiply-accumulate engine that builds the double-width `2*WIDTH` convolution sum consumed by the activation stage.
- Accepts `KLEN` (input, weight) pairs over a valid/ready handshake, adds a per-output bias, and presents one accumulated result per kernel window.
- Sits directly upstream of the activation block: it widens `WIDTH` operands to `2*WIDTH`, and the activation block narrows them back to `WIDTH`.

---
 rtl/cnn_pkg.sv | 22 ++
 rtl/mac_sat_add.sv | 44 ++++
 rtl/conv_mac_acc.sv | 102 ++++++++++
 tb/tb_conv_mac_acc.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks: operand/accumulator widths,
// MAC engine FSM encoding and the signed accumulator limits.
// Relies on the global `WIDTH macro; it defaults to 8 when not supplied.
`ifndef WIDTH
`define WIDTH 8
`endif

package cnn_pkg;

  localparam int OP_W  = `WIDTH;
  localparam int ACC_W = 2 * `WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

endpackage

// File: rtl/mac_sat_add.sv
// Combinational 2*WIDTH signed adder used by the MAC engine for both the
// bias+product and the acc+product terms.
// Optional feature macro: MAC_SAT_EN -- when defined the sum clamps to the
// signed 2*WIDTH range; otherwise it wraps in two's complement.
`ifndef WIDTH
`define WIDTH 8
`endif

module mac_sat_add
  import cnn_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] y
);

  logic signed [ACC_W-1:0] a_s;
  logic signed [ACC_W-1:0] b_s;

  assign a_s = a;
  assign b_s = b;

`ifdef MAC_SAT_EN
  // One guard bit catches overflow: it disagrees with the sign bit only when
  // the true sum is outside the representable range.
  function automatic logic signed [ACC_W-1:0] sat(input logic signed [ACC_W:0] s);
    if (s[ACC_W] != s[ACC_W-1])
      sat = s[ACC_W] ? ACC_MIN : ACC_MAX;
    else
      sat = s[ACC_W-1:0];
  endfunction

  logic signed [ACC_W:0] sum_wide;

  assign sum_wide = $signed({a_s[ACC_W-1], a_s}) + $signed({b_s[ACC_W-1], b_s});
  assign y        = sat(sum_wide);
`else
  logic signed [ACC_W-1:0] sum_wrap;

  assign sum_wrap = a_s + b_s;
  assign y        = sum_wrap;
`endif

endmodule

// File: rtl/conv_mac_acc.sv
// Streaming signed multiply-accumulate engine. Collects KLEN (x, w) pairs per
// kernel window, adds a per-window bias sampled with the first pair, and
// presents the 2*WIDTH sum until the activation stage takes it.
// Optional feature macro: MAC_SAT_EN (saturating accumulation, see mac_sat_add).
`ifndef WIDTH
`define WIDTH 8
`endif

module conv_mac_acc
  import cnn_pkg::*;
#(
  parameter int KLEN = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  x,
  input  logic [OP_W-1:0]  w,
  input  logic [ACC_W-1:0] bias,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out
);

  localparam int              CNT_W  = $clog2(KLEN + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(KLEN - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam bit              SINGLE = (KLEN == 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc;

  logic                    accept;
  logic                    last_pair;
  logic signed [OP_W-1:0]  x_s;
  logic signed [OP_W-1:0]  w_s;
  logic signed [ACC_W-1:0] prod_p0;
  logic signed [ACC_W-1:0] addend_p0;
  logic [ACC_W-1:0]        sum_p0;

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign acc_out   = acc;
  assign accept    = in_valid && in_ready;

  // A pair closes the window either as the only pair (KLEN==1) or as pair KLEN.
  assign last_pair = (state == IDLE) ? SINGLE : (cnt == LAST);

  // Stage p0: full-precision product, then folded into the bias or running sum.
  assign x_s       = x;
  assign w_s       = w;
  assign prod_p0   = ACC_W'(x_s) * ACC_W'(w_s);
  assign addend_p0 = (state == IDLE) ? $signed(bias) : acc;

  mac_sat_add u_add (
    .a (addend_p0),
    .b (prod_p0),
    .y (sum_p0)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state decode: windows advance on accepts, results leave on handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SINGLE ? HOLD : ACC;
      ACC:     if (accept && last_pair) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator and pair counter; both frozen outside accepts. The counter
  // tracks pairs of the window in progress, so it returns to 0 on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= $signed(sum_p0);
      if (last_pair)
        cnt <= '0;
      else if (state == IDLE)
        cnt <= ONE;
      else
        cnt <= cnt + ONE;
    end else if (state == HOLD && out_ready) begin
      cnt <= '0;
    end
  end

endmodule

// File: tb/tb_conv_mac_acc.sv
// Self-checking bench for conv_mac_acc with WIDTH=8, KLEN=3. Expected sums
// come from a plain-integer model of the window sum (wrap or clamp per step).
`ifndef WIDTH
`define WIDTH 8
`endif

module tb_conv_mac_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  x = '0;
  logic [7:0]  w = '0;
  logic [15:0] bias = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] acc_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  conv_mac_acc #(.KLEN(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .w         (w),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One accumulate step of the reference: exact sum, then wrap or clamp to 16 bits.
  function automatic longint fold(input longint v);
    logic [63:0]        u;
    logic signed [15:0] t;
`ifdef MAC_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    u = v;
    t = u[15:0];
    return t;
`endif
  endfunction

  function automatic longint model(input int bv, input int xs[3], input int ws[3]);
    longint a;
    a = bv;
    for (int i = 0; i < 3; i++) a = fold(a + longint'(xs[i]) * longint'(ws[i]));
    return a;
  endfunction

  // Present one pair at a negedge and return at the negedge after it is accepted.
  task automatic push(input int xv, input int wv, input int bv);
    int n;
    n = 0;
    x = 8'(xv);
    w = 8'(wv);
    bias = 16'(bv);
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("push_timeout", n, 0);
    @(negedge clk);
    in_valid = 1'b0;
    x = 8'($urandom);
    w = 8'($urandom);
    bias = 16'($urandom);
  endtask

  // Run one window: gaps idle cycles between pairs (bias scrambled during them),
  // then hold cycles of backpressure before the result is taken.
  task automatic run_window(input string tag, input int xs[3], input int ws[3],
                            input int bv, input int gaps, input int hold);
    longint exp;
    logic [15:0] first;
    exp = model(bv, xs, ws);
    out_ready = (hold == 0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        repeat (gaps) begin
          bias = 16'($urandom);
          x = 8'($urandom);
          w = 8'($urandom);
          @(negedge clk);
        end
      end
      push(xs[i], ws[i], (i == 0) ? bv : int'($urandom));
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_sum"}, $signed(acc_out), exp);
    chk({tag, "_inrdy_hold"}, in_ready, 0);
    if (hold > 0) begin
      first = acc_out;
      in_valid = 1'b1;
      repeat (hold - 1) begin
        x = 8'($urandom);
        w = 8'($urandom);
        @(negedge clk);
        chk({tag, "_bp_valid"}, out_valid, 1);
        chk({tag, "_bp_stable"}, acc_out, first);
        chk({tag, "_bp_inrdy"}, in_ready, 0);
      end
      @(negedge clk);
      chk({tag, "_bp_last"}, acc_out, first);
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_inrdy_back"}, in_ready, 1);
  endtask

  initial begin
    int xs[3];
    int ws[3];
    int bv;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc_out", acc_out, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic window.
    xs = '{1, 2, 3}; ws = '{4, 5, 6};
    chk("model_basic", model(10, xs, ws), 42);
    run_window("basic", xs, ws, 10, 0, 0);

    // Signed operands.
    xs = '{-128, 5, -1}; ws = '{127, -3, -1};
    run_window("signed", xs, ws, 0, 0, 0);
    chk("signed_value", $signed(acc_out), -16270);

    // Positive overflow.
    xs = '{-128, -128, -128}; ws = '{-128, -128, -128};
    run_window("ovf", xs, ws, 0, 0, 0);
`ifdef MAC_SAT_EN
    chk("ovf_value", $signed(acc_out), 32767);
`else
    chk("ovf_value", $signed(acc_out), -16384);
`endif

    // Negative edge of the range.
    xs = '{1, 0, 0}; ws = '{-1, 0, 0};
    run_window("negclamp", xs, ws, -32768, 0, 0);

    // Backpressure: five cycles withheld, handshake on the sixth.
    xs = '{7, -9, 11}; ws = '{3, 4, -5};
    run_window("backpressure", xs, ws, -100, 0, 5);

    // Input gaps with bias churn between pairs.
    xs = '{1, 2, 3}; ws = '{4, 5, 6};
    run_window("gaps", xs, ws, 10, 2, 0);

    // Reset in the middle of a window.
    push(9, 9, 1000);
    push(9, 9, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_acc_out", acc_out, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xs = '{1, 1, 1}; ws = '{1, 1, 1};
    run_window("fresh", xs, ws, 0, 0, 0);
    chk("fresh_value", $signed(acc_out), 3);

    // Randomized windows.
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 3; i++) begin
        xs[i] = int'($urandom_range(0, 255)) - 128;
        ws[i] = int'($urandom_range(0, 255)) - 128;
      end
      bv = int'($urandom_range(0, 65535)) - 32768;
      run_window("rand", xs, ws, bv, int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
